// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall control for a 5-stage pipeline.
// Detects load-use and ID-stage branch-operand hazards, selects ID-stage
// forwarding sources, tracks the multiply/divide unit busy window and
// chains per-stage stalls from M back to IF.
// Optional: define HAZARD_PERF_CNT_EN to build the saturating stall-cycle
// counter on Stall_Cycles; otherwise Stall_Cycles is tied to 0.
module hazard_stall_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_NeedRsByID,
    input  logic        ID_NeedRtByID,
    input  logic        ID_NeedRsByEX,
    input  logic        ID_NeedRtByEX,
    input  logic        ID_DivStart,
    input  logic        ID_HiLoAccess,
    input  logic [4:0]  EX_Rw,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  M_Rw,
    input  logic        M_RegWrite,
    input  logic        M_MemRead,
    input  logic [4:0]  WB_Rw,
    input  logic        WB_RegWrite,
    input  logic        IF_StallReq,
    input  logic        M_StallReq,
    input  logic        M_Exception,
    output logic        IF_Stall,
    output logic        ID_Stall,
    output logic        EX_Stall,
    output logic        M_Stall,
    output logic        ID_Flush,
    output logic [1:0]  ID_RsFwdSel,
    output logic [1:0]  ID_RtFwdSel,
    output logic        Div_Busy,
    output logic [31:0] Stall_Cycles
);

    localparam logic [5:0] DIV_LATENCY = 6'd33;

    logic [5:0] r_div_cnt;
    logic       w_haz_rs;
    logic       w_haz_rt;
    logic       w_m_stall;
    logic       w_id_stall;
    logic       w_if_stall;
    logic       w_div_accept;
    logic [1:0] w_rs_sel;
    logic [1:0] w_rt_sel;

    // Operand hazards: ID-stage consumers wait on any EX writer or an M load;
    // EX-stage consumers wait only on an EX load.
    always_comb begin
        w_haz_rs = (ID_Rs != 5'd0) &&
                   ((ID_NeedRsByID && EX_RegWrite && (EX_Rw == ID_Rs)) ||
                    (ID_NeedRsByID && M_MemRead   && (M_Rw  == ID_Rs)) ||
                    (ID_NeedRsByEX && EX_MemRead  && EX_RegWrite && (EX_Rw == ID_Rs)));
        w_haz_rt = (ID_Rt != 5'd0) &&
                   ((ID_NeedRtByID && EX_RegWrite && (EX_Rw == ID_Rt)) ||
                    (ID_NeedRtByID && M_MemRead   && (M_Rw  == ID_Rt)) ||
                    (ID_NeedRtByEX && EX_MemRead  && EX_RegWrite && (EX_Rw == ID_Rt)));
    end

    // Stall chain M -> EX -> ID -> IF, all forced low while reset is held.
    always_comb begin
        w_m_stall  = M_StallReq;
        w_id_stall = w_m_stall | w_haz_rs | w_haz_rt |
                     (Div_Busy & (ID_HiLoAccess | ID_DivStart));
        w_if_stall = w_id_stall | IF_StallReq;

        M_Stall  = w_m_stall  & reset;
        EX_Stall = w_m_stall  & reset;
        ID_Stall = w_id_stall & reset;
        IF_Stall = w_if_stall & reset;
        ID_Flush = M_Exception & reset;
    end

    // ID forwarding source: non-load M result beats WB result beats regfile.
    always_comb begin
        w_rs_sel = 2'b00;
        w_rt_sel = 2'b00;
        if (M_RegWrite && !M_MemRead && (M_Rw == ID_Rs) && (ID_Rs != 5'd0))
            w_rs_sel = 2'b01;
        else if (WB_RegWrite && (WB_Rw == ID_Rs) && (ID_Rs != 5'd0))
            w_rs_sel = 2'b10;
        if (M_RegWrite && !M_MemRead && (M_Rw == ID_Rt) && (ID_Rt != 5'd0))
            w_rt_sel = 2'b01;
        else if (WB_RegWrite && (WB_Rw == ID_Rt) && (ID_Rt != 5'd0))
            w_rt_sel = 2'b10;
        ID_RsFwdSel = reset ? w_rs_sel : 2'b00;
        ID_RtFwdSel = reset ? w_rt_sel : 2'b00;
    end

    assign w_div_accept = ID_DivStart & ~ID_Stall & ~ID_Flush;
    assign Div_Busy     = (r_div_cnt != 6'd0);

    // Mul/div busy counter: load on accepted start, count down to 0 and hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_div_cnt <= '0;
        else if (w_div_accept)
            r_div_cnt <= DIV_LATENCY;
        else if (r_div_cnt != 6'd0)
            r_div_cnt <= r_div_cnt - 6'd1;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of cycles with ID stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_stall_cycles <= '0;
        else if (ID_Stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign Stall_Cycles = r_stall_cycles;
`else
    assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  ID_Rs, ID_Rt;
    logic        ID_NeedRsByID, ID_NeedRtByID, ID_NeedRsByEX, ID_NeedRtByEX;
    logic        ID_DivStart, ID_HiLoAccess;
    logic [4:0]  EX_Rw;
    logic        EX_RegWrite, EX_MemRead;
    logic [4:0]  M_Rw;
    logic        M_RegWrite, M_MemRead;
    logic [4:0]  WB_Rw;
    logic        WB_RegWrite;
    logic        IF_StallReq, M_StallReq, M_Exception;
    logic        IF_Stall, ID_Stall, EX_Stall, M_Stall, ID_Flush;
    logic [1:0]  ID_RsFwdSel, ID_RtFwdSel;
    logic        Div_Busy;
    logic [31:0] Stall_Cycles;

    int total = 0;
    int fails = 0;
    int busy_cycles;

    hazard_stall_ctrl dut (
        .clock(clock), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_NeedRsByID(ID_NeedRsByID), .ID_NeedRtByID(ID_NeedRtByID),
        .ID_NeedRsByEX(ID_NeedRsByEX), .ID_NeedRtByEX(ID_NeedRtByEX),
        .ID_DivStart(ID_DivStart), .ID_HiLoAccess(ID_HiLoAccess),
        .EX_Rw(EX_Rw), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .M_Rw(M_Rw), .M_RegWrite(M_RegWrite), .M_MemRead(M_MemRead),
        .WB_Rw(WB_Rw), .WB_RegWrite(WB_RegWrite),
        .IF_StallReq(IF_StallReq), .M_StallReq(M_StallReq), .M_Exception(M_Exception),
        .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall), .M_Stall(M_Stall),
        .ID_Flush(ID_Flush),
        .ID_RsFwdSel(ID_RsFwdSel), .ID_RtFwdSel(ID_RtFwdSel),
        .Div_Busy(Div_Busy), .Stall_Cycles(Stall_Cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ID_Rs = '0; ID_Rt = '0;
        ID_NeedRsByID = 0; ID_NeedRtByID = 0; ID_NeedRsByEX = 0; ID_NeedRtByEX = 0;
        ID_DivStart = 0; ID_HiLoAccess = 0;
        EX_Rw = '0; EX_RegWrite = 0; EX_MemRead = 0;
        M_Rw = '0; M_RegWrite = 0; M_MemRead = 0;
        WB_Rw = '0; WB_RegWrite = 0;
        IF_StallReq = 0; M_StallReq = 0; M_Exception = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;

        // Outputs held quiet during reset even with active requests.
        M_StallReq = 1; IF_StallReq = 1; M_Exception = 1;
        M_RegWrite = 1; M_Rw = 5'd3; ID_Rs = 5'd3;
        WB_RegWrite = 1; WB_Rw = 5'd4; ID_Rt = 5'd4;
        #2;
        chk("rst_M_Stall", {31'b0, M_Stall}, 32'd0);
        chk("rst_IF_Stall", {31'b0, IF_Stall}, 32'd0);
        chk("rst_ID_Stall", {31'b0, ID_Stall}, 32'd0);
        chk("rst_ID_Flush", {31'b0, ID_Flush}, 32'd0);
        chk("rst_RsFwd", {30'b0, ID_RsFwdSel}, 32'd0);
        chk("rst_RtFwd", {30'b0, ID_RtFwdSel}, 32'd0);
        chk("rst_Div_Busy", {31'b0, Div_Busy}, 32'd0);
        chk("rst_Stall_Cycles", Stall_Cycles, 32'd0);
        step();
        step();
        clear_inputs();
        reset = 1'b1;
        step();

        // Load-use hazard.
        EX_MemRead = 1; EX_RegWrite = 1; EX_Rw = 5'd5; ID_Rs = 5'd5; ID_NeedRsByEX = 1;
        #1;
        chk("lu_ID_Stall", {31'b0, ID_Stall}, 32'd1);
        chk("lu_IF_Stall", {31'b0, IF_Stall}, 32'd1);
        chk("lu_EX_Stall", {31'b0, EX_Stall}, 32'd0);
        ID_Rs = 5'd0; EX_Rw = 5'd0;
        #1;
        chk("lu_r0_ID_Stall", {31'b0, ID_Stall}, 32'd0);
        clear_inputs();

        // ID consumer behind a non-load EX writer stalls.
        ID_NeedRsByID = 1; ID_Rs = 5'd7; EX_RegWrite = 1; EX_Rw = 5'd7;
        #1;
        chk("exw_ID_Stall", {31'b0, ID_Stall}, 32'd1);
        clear_inputs();

        // Branch operand forwarding.
        ID_NeedRtByID = 1; ID_Rt = 5'd9; M_RegWrite = 1; M_MemRead = 0; M_Rw = 5'd9;
        WB_Rw = 5'd9; WB_RegWrite = 1;
        #1;
        chk("br_RtFwd_M", {30'b0, ID_RtFwdSel}, 32'd1);
        chk("br_ID_Stall", {31'b0, ID_Stall}, 32'd0);
        chk("br_RsFwd_r0", {30'b0, ID_RsFwdSel}, 32'd0);
        M_MemRead = 1;
        #1;
        chk("br_load_ID_Stall", {31'b0, ID_Stall}, 32'd1);
        chk("br_load_RtFwd_WB", {30'b0, ID_RtFwdSel}, 32'd2);
        M_MemRead = 0; M_RegWrite = 0; ID_Rs = 5'd9;
        #1;
        chk("wb_RsFwd", {30'b0, ID_RsFwdSel}, 32'd2);
        clear_inputs();

        // Stall chain.
        M_StallReq = 1;
        #1;
        chk("ch_M_Stall", {31'b0, M_Stall}, 32'd1);
        chk("ch_EX_Stall", {31'b0, EX_Stall}, 32'd1);
        chk("ch_ID_Stall", {31'b0, ID_Stall}, 32'd1);
        chk("ch_IF_Stall", {31'b0, IF_Stall}, 32'd1);
        M_Exception = 1;
        #1;
        chk("exc_ID_Flush", {31'b0, ID_Flush}, 32'd1);
        chk("exc_M_Stall_kept", {31'b0, M_Stall}, 32'd1);
        M_StallReq = 0; M_Exception = 0; IF_StallReq = 1;
        #1;
        chk("ifreq_IF_Stall", {31'b0, IF_Stall}, 32'd1);
        chk("ifreq_ID_Stall", {31'b0, ID_Stall}, 32'd0);
        chk("ifreq_M_Stall", {31'b0, M_Stall}, 32'd0);
        clear_inputs();

        // Start coincident with exception is dropped.
        ID_DivStart = 1; M_Exception = 1;
        step();
        clear_inputs();
        chk("div_exc_drop", {31'b0, Div_Busy}, 32'd0);

        // Accepted divide: busy for exactly 33 cycles; restart while busy ignored.
        ID_DivStart = 1;
        step();
        ID_DivStart = 0;
        busy_cycles = 0;
        while (Div_Busy && busy_cycles < 40) begin
            busy_cycles++;
            if (busy_cycles == 5) begin
                ID_DivStart = 1;
                #1;
                chk("div_restart_stall", {31'b0, ID_Stall}, 32'd1);
            end
            if (busy_cycles == 10) begin
                ID_HiLoAccess = 1;
                #1;
                chk("div_hilo_stall", {31'b0, ID_Stall}, 32'd1);
            end
            step();
            ID_DivStart = 0; ID_HiLoAccess = 0;
        end
        chk("div_busy_cycles", busy_cycles, 32'd33);
        ID_HiLoAccess = 1;
        #1;
        chk("div_done_hilo", {31'b0, ID_Stall}, 32'd0);
        clear_inputs();

        // Reset in the middle of a divide.
        ID_DivStart = 1;
        step();
        ID_DivStart = 0;
        repeat (13) step();
        #2 reset = 1'b0;
        #1;
        chk("rmid_Div_Busy", {31'b0, Div_Busy}, 32'd0);
        chk("rmid_Stall_Cycles", Stall_Cycles, 32'd0);
        step();
        reset = 1'b1;
        step();
        chk("rmid_after_release", {31'b0, Div_Busy}, 32'd0);

        // Stall-cycle performance counter.
        M_StallReq = 1;
        repeat (7) step();
        M_StallReq = 0;
        step();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_7", Stall_Cycles, 32'd7);
        force dut.r_stall_cycles = 32'hFFFFFFFF;
        #1;
        release dut.r_stall_cycles;
        M_StallReq = 1;
        step();
        M_StallReq = 0;
        step();
        chk("perf_sat", Stall_Cycles, 32'hFFFFFFFF);
`else
        chk("perf_off", Stall_Cycles, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have a single clock `clock` and an asynchronous, active-low reset `reset`.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), listed one per line:
  - clock  in  1  rising-edge clock
  - reset  in  1  asynchronous active-low reset
  - ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID
  - ID_NeedRsByID, ID_NeedRtByID  in  1 each  the operand is consumed in ID (branch compare)
  - ID_NeedRsByEX, ID_NeedRtByEX  in  1 each  the operand is consumed in EX
  - ID_DivStart  in  1  ID holds a DIV/DIVU/MULT/MULTU
  - ID_HiLoAccess  in  1  ID holds an MFHI/MFLO/MTHI/MTLO
  - EX_Rw  in  5  destination register in EX
  - EX_RegWrite, EX_MemRead  in  1 each  EX writes a register; EX is a load
  - M_Rw  in  5  destination register in M
  - M_RegWrite, M_MemRead  in  1 each  M writes a register; M is a load
  - WB_Rw  in  5  destination register in WB
  - WB_RegWrite  in  1  WB writes a register
  - IF_StallReq, M_StallReq  in  1 each  I-cache miss; D-cache / bus busy
  - M_Exception  in  1  an exception is taken in M
  - IF_Stall, ID_Stall, EX_Stall, M_Stall  out  1 each  per-stage stall
  - ID_Flush  out  1  squash the instruction in ID into the ID/EX register
  - ID_RsFwdSel, ID_RtFwdSel  out  2 each  ID operand source: 00 regfile, 01 M result, 10 WB result
  - Div_Busy  out  1  the multiply/divide unit is busy
  - Stall_Cycles  out  32  performance counter (see Configuration)

Function
REQ-003 Stall outputs and forward selects SHALL be combinational from inputs and state; there is no added latency.
REQ-004 The hazard term for each operand x in {Rs, Rt} SHALL be defined as follows:
  - hazard_x = (ID_x != 0) AND any of:
    - NeedByID and EX_RegWrite and EX_Rw == ID_x;
    - NeedByID and M_MemRead and M_Rw == ID_x;
    - NeedByEX and EX_MemRead and EX_RegWrite and EX_Rw == ID_x.
REQ-005 The stall outputs SHALL be derived as follows:
  - M_Stall = M_StallReq.
  - EX_Stall = M_Stall.
  - ID_Stall = EX_Stall | hazard_Rs | hazard_Rt | (Div_Busy & (ID_HiLoAccess | ID_DivStart)).
  - IF_Stall = ID_Stall | IF_StallReq.
REQ-006 ID_Flush SHALL equal M_Exception.
  - M_Exception does not clear any stall output.
REQ-007 The forward select for each operand x SHALL be chosen as follows:
  - 01 if M_RegWrite & !M_MemRead & M_Rw == ID_x & ID_x != 0;
  - otherwise 10 if WB_RegWrite & WB_Rw == ID_x & ID_x != 0;
  - otherwise 00.
  - M has priority over WB.
REQ-008 The busy counter SHALL be a 6-bit counter `div_cnt`, with Div_Busy = (div_cnt != 0).
REQ-009 A mul/div start SHALL be accepted when ID_DivStart & !ID_Stall & !ID_Flush; an accepted start loads div_cnt = 33.
REQ-010 When no start is accepted and div_cnt != 0, div_cnt SHALL decrement by 1 every cycle; it decrements even while stalled.
REQ-011 The counter SHALL never wrap.
  - At 0 it holds 0.
  - A start while busy is never accepted, because ID_Stall is asserted by REQ-005.
REQ-012 When M_Exception and a start occur in the same cycle, the start SHALL be dropped.
  - A divide already in progress still runs to completion.

Reset
REQ-013 Asserting `reset` SHALL immediately clear div_cnt and Stall_Cycles to 0, with no dependence on `clock`.
REQ-014 While `reset` is asserted, IF_Stall, ID_Stall, EX_Stall, M_Stall and ID_Flush SHALL be 0, and both forward selects SHALL be 00.
REQ-015 A reset in the middle of a divide SHALL abort it, so Div_Busy = 0 on the first cycle after release.

Configuration
REQ-016 The macro HAZARD_PERF_CNT_EN SHALL control a stall-cycle counter.
  - When the macro is defined, Stall_Cycles increments by 1 on each rising clock edge where ID_Stall = 1.
  - The counter saturates at 32'hFFFFFFFF.
REQ-017 When HAZARD_PERF_CNT_EN is not defined, Stall_Cycles SHALL be tied to 0 and no counter flops are generated.

Verification
REQ-018 The bench SHALL cover a load-use case:
  - Stimulus: EX_MemRead = 1, EX_RegWrite = 1, EX_Rw = 5, ID_Rs = 5, ID_NeedRsByEX = 1.
  - Required response: ID_Stall = 1 and IF_Stall = 1, while EX_Stall = 0.
  - With ID_Rs = 0 instead: ID_Stall = 0.
REQ-019 The bench SHALL cover a branch operand case:
  - Stimulus: ID_NeedRtByID = 1, ID_Rt = 9, and M_RegWrite = 1, M_MemRead = 0, M_Rw = 9, WB_Rw = 9, WB_RegWrite = 1.
  - Required response: ID_RtFwdSel = 01 and ID_Stall = 0.
  - With M_MemRead = 1 instead: ID_Stall = 1.
REQ-020 The bench SHALL cover a divide case:
  - Stimulus: pulse an accepted ID_DivStart for 1 cycle.
  - Required response: Div_Busy stays high for exactly 33 cycles.
  - ID_HiLoAccess = 1 during that window gives ID_Stall = 1.
  - ID_HiLoAccess = 1 on the cycle after Div_Busy falls gives ID_Stall = 0.
REQ-021 The bench SHALL cover a stall chain case:
  - Stimulus: M_StallReq = 1.
  - Required response: M_Stall, EX_Stall, ID_Stall and IF_Stall all = 1.
  - IF_StallReq alone gives only IF_Stall = 1.
REQ-022 The bench SHALL cover a reset-mid-divide case:
  - Stimulus: assert `reset` asynchronously at div_cnt = 20.
  - Required response: Div_Busy = 0 and Stall_Cycles = 0 before the next clock edge.
REQ-023 The bench SHALL cover the performance counter with HAZARD_PERF_CNT_EN defined:
  - Stimulus: 7 stall cycles.
  - Required response: Stall_Cycles = 7.
  - Stimulus: preload 32'hFFFFFFFF, then one more stall cycle.
  - Required response: Stall_Cycles holds at 32'hFFFFFFFF.
